dpi_flow_ctx_feeder: RTL and testbench

//  Upstream feeder for one DFA regex engine. Takes byte-wide packet beats tagged with a flow ID.
//  At packet start it restores that flow's saved DFA state into the engine, then streams bytes to it.
//  At packet end it saves the engine's final state. Engine accepts become match events (flow + offset).

---
 rtl/dpi_pkg.sv | 23 ++
 rtl/dpi_ctx_ram.sv | 47 ++++
 rtl/dpi_flow_ctx_feeder.sv | 142 ++++++++++++++
 tb/tb_dpi_flow_ctx_feeder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_pkg.sv
// Shared types and default widths for the DPI flow-context feeder.
package dpi_pkg;

  localparam int unsigned StateWDef = 11;
  localparam int unsigned FlowWDef  = 4;
  localparam int unsigned OfsWDef   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStream,
    StSave
  } feeder_st_e;

  // Request bundle towards the DFA engine
  typedef struct packed {
    logic [7:0]           chr;
    logic                 chr_vld;
    logic [StateWDef-1:0] state;
    logic                 state_vld;
  } eng_req_t;

endpackage

// File: rtl/dpi_ctx_ram.sv
// Per-flow DFA context store: 1R1W sync-read RAM plus a flop-based valid vector.
module dpi_ctx_ram #(
  parameter int unsigned STATE_W = 11,
  parameter int unsigned FLOW_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en_i,
  input  logic [FLOW_W-1:0]  rd_addr_i,
  output logic [STATE_W-1:0] rd_data_o,
  input  logic               wr_en_i,
  input  logic [FLOW_W-1:0]  wr_addr_i,
  input  logic [STATE_W-1:0] wr_data_i,
  input  logic               clr_i,
  input  logic [FLOW_W-1:0]  vld_addr_i,
  output logic               vld_o
);

  localparam int unsigned Depth = 1 << FLOW_W;

  logic [STATE_W-1:0] mem_q [Depth];
  logic [STATE_W-1:0] rd_data_q;
  logic [Depth-1:0]   vld_q, vld_d;

  // Data array has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  // Valid vector: a clear in the same cycle as a save wins
  always_comb begin
    vld_d = vld_q;
    if (wr_en_i) vld_d[wr_addr_i] = 1'b1;
    if (clr_i)   vld_d = '0;
  end

  // Valid vector register
  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  assign rd_data_o = rd_data_q;
  assign vld_o     = vld_q[vld_addr_i];

endmodule

// File: rtl/dpi_flow_ctx_feeder.sv
// Feeds byte beats into a DFA engine, restoring/saving per-flow engine state around each packet.
module dpi_flow_ctx_feeder
  import dpi_pkg::*;
#(
  parameter int unsigned STATE_W = StateWDef,
  parameter int unsigned FLOW_W  = FlowWDef,
  parameter int unsigned OFS_W   = OfsWDef
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic               s_sop,
  input  logic               s_eop,
  input  logic [FLOW_W-1:0]  s_flow,
  input  logic               ctx_clr,
  output logic [7:0]         eng_char,
  output logic               eng_char_vld,
  output logic [STATE_W-1:0] eng_state,
  output logic               eng_state_vld,
  input  logic [STATE_W-1:0] eng_cur,
  input  logic               eng_accept,
  output logic               match_vld,
  output logic [FLOW_W-1:0]  match_flow,
  output logic [OFS_W-1:0]   match_ofs,
  output logic               err_sop,
  output logic               busy
);

  feeder_st_e         st_q, st_d;
  logic [FLOW_W-1:0]  flow_q, flow_d;
  logic [OFS_W-1:0]   ofs_q, ofs_d;
  logic               match_vld_q, err_sop_q;
  logic [FLOW_W-1:0]  match_flow_q;
  logic [OFS_W-1:0]   match_ofs_q;
  logic               rd_en, wr_en, beat, ctx_vld;
  logic [STATE_W-1:0] ram_q;
  eng_req_t           eng_req;

  dpi_ctx_ram #(
    .STATE_W (STATE_W),
    .FLOW_W  (FLOW_W)
  ) u_ctx_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_i    (rd_en),
    .rd_addr_i  (s_flow),
    .rd_data_o  (ram_q),
    .wr_en_i    (wr_en),
    .wr_addr_i  (flow_q),
    .wr_data_i  (eng_cur),
    .clr_i      (ctx_clr),
    .vld_addr_i (flow_q),
    .vld_o      (ctx_vld)
  );

  // Next-state and engine-side outputs
  always_comb begin
    st_d    = st_q;
    flow_d  = flow_q;
    ofs_d   = ofs_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    s_ready = 1'b0;
    beat    = 1'b0;
    eng_req = '0;
    unique case (st_q)
      StIdle: begin
        // The sop beat is only peeked here; it is consumed in StStream
        if (s_valid && s_sop) begin
          flow_d = s_flow;
          rd_en  = 1'b1;
          st_d   = StLoad;
        end
      end
      StLoad: begin
        eng_req.state_vld = 1'b1;
        eng_req.state     = StateWDef'(ctx_vld ? ram_q : {STATE_W{1'b0}});
        ofs_d             = '0;
        st_d              = StStream;
      end
      StStream: begin
        s_ready         = 1'b1;
        eng_req.chr     = s_data;
        eng_req.chr_vld = s_valid;
        beat            = s_valid;
        if (beat) begin
          if (ofs_q != '1) ofs_d = ofs_q + OFS_W'(1);
          if (s_eop) st_d = StSave;
        end
      end
      StSave: begin
        // A reset landing on SAVE drops the packet without writing
        wr_en = rst_n;
        st_d  = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  // FSM and packet bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= StIdle;
      flow_q <= '0;
      ofs_q  <= '0;
    end else begin
      st_q   <= st_d;
      flow_q <= flow_d;
      ofs_q  <= ofs_d;
    end
  end

  // Match and error event registers; ofs_q is zero only on the first beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_vld_q  <= 1'b0;
      match_flow_q <= '0;
      match_ofs_q  <= '0;
      err_sop_q    <= 1'b0;
    end else begin
      match_vld_q <= beat && eng_accept;
      err_sop_q   <= beat && s_sop && (ofs_q != '0);
      if (beat && eng_accept) begin
        match_flow_q <= flow_q;
        match_ofs_q  <= ofs_q;
      end
    end
  end

  assign eng_char      = eng_req.chr;
  assign eng_char_vld  = eng_req.chr_vld;
  assign eng_state     = STATE_W'(eng_req.state);
  assign eng_state_vld = eng_req.state_vld;
  assign match_vld     = match_vld_q;
  assign match_flow    = match_flow_q;
  assign match_ofs     = match_ofs_q;
  assign err_sop       = err_sop_q;
  assign busy          = (st_q != StIdle);

endmodule

// File: tb/tb_dpi_flow_ctx_feeder.sv
// Randomized bench for dpi_flow_ctx_feeder with a stub DFA engine and a per-flow context model.
module tb_dpi_flow_ctx_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0, ctx_clr = 1'b0;
  logic [7:0]  s_data = '0;
  logic [3:0]  s_flow = '0;
  logic        s_ready;
  logic [7:0]  eng_char;
  logic        eng_char_vld, eng_state_vld, eng_accept;
  logic [10:0] eng_state, eng_cur, eng_st;
  logic        match_vld, err_sop, busy;
  logic [3:0]  match_flow;
  logic [15:0] match_ofs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: saved context per flow plus expected next-cycle events
  logic [10:0] m_val [16];
  bit          m_vld [16];
  bit          exp_mv, exp_err;
  logic [3:0]  exp_mflow;
  logic [15:0] exp_mofs;
  logic [7:0]  pkt_q [$];

  always #5 clk = ~clk;

  dpi_flow_ctx_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_sop         (s_sop),
    .s_eop         (s_eop),
    .s_flow        (s_flow),
    .ctx_clr       (ctx_clr),
    .eng_char      (eng_char),
    .eng_char_vld  (eng_char_vld),
    .eng_state     (eng_state),
    .eng_state_vld (eng_state_vld),
    .eng_cur       (eng_cur),
    .eng_accept    (eng_accept),
    .match_vld     (match_vld),
    .match_flow    (match_flow),
    .match_ofs     (match_ofs),
    .err_sop       (err_sop),
    .busy          (busy)
  );

  // Stub engine: state loads on state_in, +1 per char, accepts on newline
  always @(posedge clk) begin
    if (!rst_n)             eng_st <= '0;
    else if (eng_state_vld) eng_st <= eng_state;
    else if (eng_char_vld)  eng_st <= eng_st + 11'd1;
  end
  assign eng_cur    = eng_st;
  assign eng_accept = eng_char_vld && (eng_char == 8'h0A);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_events();
    check_eq("match_vld", 32'(match_vld), 32'(exp_mv));
    if (exp_mv) begin
      check_eq("match_flow", 32'(match_flow), 32'(exp_mflow));
      check_eq("match_ofs", 32'(match_ofs), 32'(exp_mofs));
    end
    check_eq("err_sop", 32'(err_sop), 32'(exp_err));
  endtask

  task automatic model_clear_all();
    for (int f = 0; f < 16; f++) m_vld[f] = 1'b0;
  endtask

  // Sends pkt_q on a flow. gaps: 0 none, 1 random, 2 every other cycle.
  // clr_mode: 0 none, 1 ctx_clr during SAVE, 2 ctx_clr on the first stream beat.
  task automatic send_pkt(input int flow, input int gaps, input int clr_mode, input int err_idx);
    int          n;
    bit          gap;
    logic [10:0] exp_load, st;
    logic [15:0] ofs;
    n        = pkt_q.size();
    exp_load = m_vld[flow] ? m_val[flow] : 11'd0;
    s_valid  = 1'b1;
    s_sop    = 1'b1;
    s_eop    = (n == 1);
    s_data   = pkt_q[0];
    s_flow   = 4'(flow);
    #1;
    check_eq("idle_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    s_flow = 4'($urandom);
    #1;
    check_eq("load_vld", 32'(eng_state_vld), 32'd1);
    check_eq("load_state", 32'(eng_state), 32'(exp_load));
    check_eq("load_ready", 32'(s_ready), 32'd0);
    check_eq("load_char_vld", 32'(eng_char_vld), 32'd0);
    check_eq("load_busy", 32'(busy), 32'd1);
    check_events();
    @(negedge clk);
    ofs = '0;
    st  = exp_load;
    for (int i = 0; i < n; i++) begin
      gap = (i > 0) && ((gaps == 2) || (gaps == 1 && $urandom_range(1, 0) == 1));
      if (gap) begin
        s_valid = 1'b0;
        s_sop   = 1'b0;
        #1;
        check_eq("gap_ready", 32'(s_ready), 32'd1);
        check_eq("gap_char_vld", 32'(eng_char_vld), 32'd0);
        check_events();
        exp_mv  = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = pkt_q[i];
      s_sop   = (i == 0) || (i == err_idx);
      s_eop   = (i == n - 1);
      ctx_clr = (clr_mode == 2 && i == 0);
      #1;
      check_eq("beat_ready", 32'(s_ready), 32'd1);
      check_eq("beat_char_vld", 32'(eng_char_vld), 32'd1);
      check_eq("beat_char", 32'(eng_char), 32'(pkt_q[i]));
      check_eq("beat_state_vld", 32'(eng_state_vld), 32'd0);
      check_eq("beat_busy", 32'(busy), 32'd1);
      check_events();
      exp_mv    = (pkt_q[i] == 8'h0A);
      exp_mflow = 4'(flow);
      exp_mofs  = ofs;
      exp_err   = (i > 0) && (i == err_idx);
      if (ofs != 16'hFFFF) ofs = ofs + 16'd1;
      st = st + 11'd1;
      @(negedge clk);
      ctx_clr = 1'b0;
    end
    if (clr_mode == 2) model_clear_all();
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
    ctx_clr = (clr_mode == 1);
    #1;
    check_eq("save_ready", 32'(s_ready), 32'd0);
    check_eq("save_busy", 32'(busy), 32'd1);
    check_eq("save_char_vld", 32'(eng_char_vld), 32'd0);
    check_events();
    exp_mv  = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    ctx_clr = 1'b0;
    #1;
    check_eq("post_busy", 32'(busy), 32'd0);
    check_events();
    if (clr_mode == 1) begin
      model_clear_all();
    end else begin
      m_vld[flow] = 1'b1;
      m_val[flow] = st;
    end
  endtask

  task automatic rand_pkt(input int len);
    pkt_q.delete();
    for (int i = 0; i < len; i++)
      pkt_q.push_back(($urandom_range(3, 0) == 0) ? 8'h0A : 8'($urandom));
  endtask

  initial begin
    int len, cm, ei;
    logic [7:0] b;
    model_clear_all();
    exp_mv  = 1'b0;
    exp_err = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(s_ready), 32'd0);
    check_eq("rst_state_vld", 32'(eng_state_vld), 32'd0);
    check_eq("rst_char_vld", 32'(eng_char_vld), 32'd0);
    check_eq("rst_state", 32'(eng_state), 32'd0);
    check_eq("rst_match_flow", 32'(match_flow), 32'd0);
    check_eq("rst_match_ofs", 32'(match_ofs), 32'd0);
    check_events();
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh flow 3, then interleaved flow 5, then flow 3 restored
    pkt_q = '{8'h41, 8'h42, 8'h0A};
    send_pkt(3, 0, 0, -1);
    rand_pkt(4);
    send_pkt(5, 0, 0, -1);
    pkt_q = '{8'h78, 8'h79};
    send_pkt(3, 0, 0, -1);
    check_eq("model_flow3", 32'(m_val[3]), 32'd5);

    // ctx_clr pulse in idle, then flow 3 loads zero
    ctx_clr = 1'b1;
    @(negedge clk);
    ctx_clr = 1'b0;
    model_clear_all();
    rand_pkt(2);
    send_pkt(3, 0, 0, -1);

    // ctx_clr coincident with SAVE of flow 7
    rand_pkt(3);
    send_pkt(7, 0, 1, -1);
    rand_pkt(3);
    send_pkt(7, 0, 0, -1);

    // ctx_clr mid-packet does not stop the save
    rand_pkt(3);
    send_pkt(9, 0, 2, -1);
    rand_pkt(2);
    send_pkt(9, 0, 0, -1);

    // Alternating valid with newlines, plus a mid-packet sop
    pkt_q = '{8'h61, 8'h0A, 8'h62, 8'h0A, 8'h63};
    send_pkt(2, 2, 0, 3);

    // Single-beat packet
    pkt_q = '{8'h0A};
    send_pkt(1, 0, 0, -1);

    // Non-sop beat in idle is held
    s_valid = 1'b1;
    s_sop   = 1'b0;
    s_data  = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_eq("held_ready", 32'(s_ready), 32'd0);
      check_eq("held_busy", 32'(busy), 32'd0);
      check_eq("held_char_vld", 32'(eng_char_vld), 32'd0);
    end
    s_valid = 1'b0;
    @(negedge clk);

    // Random traffic
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(10, 1);
      rand_pkt(len);
      cm  = $urandom_range(9, 0);
      cm  = (cm == 0) ? 1 : ((cm == 1) ? 2 : 0);
      ei  = (len > 1 && $urandom_range(3, 0) == 0) ? $urandom_range(len - 1, 1) : -1;
      send_pkt($urandom_range(15, 0), $urandom_range(1, 0), cm, ei);
    end

    // Reset mid-packet
    s_valid = 1'b1;
    s_sop   = 1'b1;
    s_data  = 8'h41;
    s_flow  = 4'd6;
    @(negedge clk);
    @(negedge clk);
    s_sop = 1'b0;
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ready", 32'(s_ready), 32'd0);
    check_eq("midrst_match", 32'(match_vld), 32'd0);
    rst_n = 1'b1;
    model_clear_all();
    @(negedge clk);
    rand_pkt(3);
    send_pkt(6, 0, 0, -1);

    // Long packet: offset runs to 299
    pkt_q.delete();
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom);
      if (b == 8'h0A) b = 8'h0B;
      pkt_q.push_back((i == 150 || i == 299) ? 8'h0A : b);
    end
    send_pkt(4, 0, 0, -1);
    send_pkt(4, 1, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
